// File: rtl/npc_defs.sv
// Shared definitions for the memory arbiter: widths, FSM encoding, defaults.
package npc_defs;

  localparam int unsigned ADDR_W       = 64;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned WLEN_W       = 4;
  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam int unsigned FAIR_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IF = 2'd1,
    ST_GRANT_LS = 2'd2
  } arb_state_t;

  // Latched memory access command
  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WLEN_W-1:0] wlen;
  } mem_cmd_t;

  // Bits needed to hold a counter that reaches max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd2) ? 32'd1 : 32'($clog2(max_val + 32'd1));
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Requester selection with an LSU-starvation guard for the IFU.
module mem_arb_select
  import npc_defs::*;
#(
  parameter int unsigned FAIR_MAX = FAIR_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  output logic o_ifu_grant_c,
  output logic o_lsu_grant_c
);

  localparam int unsigned FAIR_W = cnt_width(FAIR_MAX);

  logic [FAIR_W-1:0] r_fair_cnt;
  logic              w_fair_full;
  logic              w_open;

  assign w_fair_full = (r_fair_cnt == FAIR_W'(FAIR_MAX));
  assign w_open      = i_idle & ~rst;

  // LSU has priority until it has won FAIR_MAX times in a row over a waiting IFU
  assign o_ifu_grant_c = w_open & i_ifu_valid & (~i_lsu_valid | w_fair_full);
  assign o_lsu_grant_c = w_open & i_lsu_valid & ~(i_ifu_valid & w_fair_full);

  // Count consecutive LSU wins while the IFU waits; an IFU grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fair_cnt <= '0;
    end else if (o_ifu_grant_c) begin
      r_fair_cnt <= '0;
    end else if (o_lsu_grant_c && i_ifu_valid && !w_fair_full) begin
      r_fair_cnt <= r_fair_cnt + FAIR_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single-outstanding memory port.
module mem_arbiter
  import npc_defs::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned FAIR_MAX = FAIR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [WLEN_W-1:0] lsu_req_wlen,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [WLEN_W-1:0] mem_wlen,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam int unsigned WAIT_W = cnt_width(TIMEOUT);

  arb_state_t        r_state;
  mem_cmd_t          r_cmd;
  logic              r_mem_req;
  logic              r_ifu_resp_valid;
  logic              r_lsu_resp_valid;
  logic [DATA_W-1:0] r_ifu_resp_data;
  logic [DATA_W-1:0] r_lsu_resp_data;
  logic              r_bus_err;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic w_idle;
  logic w_ifu_grant;
  logic w_lsu_grant;
  logic w_timeout;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_timeout = (r_wait_cnt == WAIT_W'(TIMEOUT - 32'd1));

  mem_arb_select #(
    .FAIR_MAX(FAIR_MAX)
  ) u_select (
    .clk          (clk),
    .rst          (rst),
    .i_idle       (w_idle),
    .i_ifu_valid  (ifu_req_valid),
    .i_lsu_valid  (lsu_req_valid),
    .o_ifu_grant_c(w_ifu_grant),
    .o_lsu_grant_c(w_lsu_grant)
  );

  // Grants only carry valid requests, so ready doubles as the accept strobe
  assign ifu_req_ready  = w_ifu_grant;
  assign lsu_req_ready  = w_lsu_grant;
  assign ifu_resp_valid = r_ifu_resp_valid;
  assign ifu_resp_data  = r_ifu_resp_data;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign lsu_resp_data  = r_lsu_resp_data;
  assign mem_req        = r_mem_req;
  assign mem_wen        = r_cmd.wen;
  assign mem_addr       = r_cmd.addr;
  assign mem_wdata      = r_cmd.wdata;
  assign mem_wlen       = r_cmd.wlen;
  assign bus_err        = r_bus_err;

  // Arbiter FSM: accept in IDLE, hold the access until ack or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_cmd            <= '0;
      r_mem_req        <= 1'b0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_ifu_resp_data  <= '0;
      r_lsu_resp_data  <= '0;
      r_bus_err        <= 1'b0;
      r_wait_cnt       <= '0;
    end else begin
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_bus_err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ifu_grant) begin
            r_cmd.wen   <= 1'b0;
            r_cmd.addr  <= ifu_req_addr;
            r_cmd.wdata <= '0;
            r_cmd.wlen  <= '0;
            r_mem_req   <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= ST_GRANT_IF;
          end else if (w_lsu_grant) begin
            r_cmd.wen   <= lsu_req_wen;
            r_cmd.addr  <= lsu_req_addr;
            r_cmd.wdata <= lsu_req_wdata;
            r_cmd.wlen  <= lsu_req_wlen;
            r_mem_req   <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= ST_GRANT_LS;
          end
        end
        ST_GRANT_IF, ST_GRANT_LS: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= ST_IDLE;
            if (r_state == ST_GRANT_IF) begin
              r_ifu_resp_valid <= 1'b1;
              r_ifu_resp_data  <= mem_rdata;
            end else begin
              r_lsu_resp_valid <= 1'b1;
              r_lsu_resp_data  <= r_cmd.wen ? '0 : mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_req  <= 1'b0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b1;
            r_state    <= ST_IDLE;
            if (r_state == ST_GRANT_IF) begin
              r_ifu_resp_valid <= 1'b1;
              r_ifu_resp_data  <= '0;
            end else begin
              r_lsu_resp_valid <= 1'b1;
              r_lsu_resp_data  <= '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [63:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wlen;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_wlen;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        bus_err;

  mem_arbiter #(.TIMEOUT(8), .FAIR_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data (ifu_resp_data),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wlen  (lsu_req_wlen),
    .lsu_req_ready (lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_data (lsu_resp_data),
    .mem_req       (mem_req),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wlen      (mem_wlen),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  wlen;
    int          ack_lat;
    logic [63:0] rdata;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  int   n_chk = 0;
  int   n_err = 0;
  int   g, req_cyc, err_cyc, resp_cyc, both_cyc, other_cyc;
  logic [63:0] resp_d;
  bit   exp_order[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One lone request: accept, hold for ack_lat grant cycles, check response pulse
  task automatic run_vec(input vec_t v);
    if (v.lsu) begin
      lsu_req_valid = 1'b1;
      lsu_req_wen   = v.wen;
      lsu_req_addr  = v.addr;
      lsu_req_wdata = v.wdata;
      lsu_req_wlen  = v.wlen;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_req_addr  = v.addr;
    end
    #1;
    chk("own_ready", 64'(v.lsu ? lsu_req_ready : ifu_req_ready), 64'd1);
    chk("other_ready", 64'(v.lsu ? ifu_req_ready : lsu_req_ready), 64'd0);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_req_addr  = ~v.addr;
    lsu_req_addr  = ~v.addr;
    lsu_req_wdata = ~v.wdata;
    lsu_req_wen   = ~v.wen;
    lsu_req_wlen  = ~v.wlen;
    for (int c = 1; c <= v.ack_lat; c++) begin
      chk("mem_req", 64'(mem_req), 64'd1);
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_wen", 64'(mem_wen), 64'(v.lsu ? v.wen : 1'b0));
      if (v.lsu) begin
        chk("mem_wdata", mem_wdata, v.wdata);
        chk("mem_wlen", 64'(mem_wlen), 64'(v.wlen));
      end
      chk("early_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      if (c == v.ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    chk("resp_valid", 64'(v.lsu ? lsu_resp_valid : ifu_resp_valid), 64'd1);
    chk("resp_data", v.lsu ? lsu_resp_data : ifu_resp_data, v.exp_data);
    chk("nonowner_resp", 64'(v.lsu ? ifu_resp_valid : lsu_resp_valid), 64'd0);
    chk("mem_req_drop", 64'(mem_req), 64'd0);
    chk("no_bus_err", 64'(bus_err), 64'd0);
    tick();
    chk("resp_one_cycle", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{lsu: 1'b0, wen: 1'b0, addr: 64'h0000_0000_8000_0000, wdata: 64'h0, wlen: 4'h0,
                ack_lat: 1, rdata: 64'h13, exp_data: 64'h13};
    vecs[1] = '{lsu: 1'b1, wen: 1'b1, addr: 64'h0000_0000_8000_1000, wdata: 64'h0000_0000_DEAD_BEEF,
                wlen: 4'b1111, ack_lat: 3, rdata: 64'h5555_5555, exp_data: 64'h0};
    vecs[2] = '{lsu: 1'b1, wen: 1'b0, addr: 64'h0000_0000_8000_2008, wdata: 64'hAA, wlen: 4'b0011,
                ack_lat: 2, rdata: 64'h0123_4567_89AB_CDEF, exp_data: 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{lsu: 1'b0, wen: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFF8, wdata: 64'h0, wlen: 4'h0,
                ack_lat: 5, rdata: 64'h0000_0000_CAFE_F00D, exp_data: 64'h0000_0000_CAFE_F00D};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
    lsu_req_wdata = '0;   lsu_req_wlen = '0;
    mem_ack = 1'b0;       mem_rdata = '0;

    // Reset: outputs quiet, readies held low even with both requesters valid
    tick();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Both requesters continuously valid, ack latency 1: LSU x4, IFU, repeat
    ifu_req_valid = 1'b1; ifu_req_addr  = 64'h1000;
    lsu_req_valid = 1'b1; lsu_req_addr  = 64'h2000; lsu_req_wen = 1'b0;
    mem_rdata = 64'h42;
    g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      mem_ack = mem_req;
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        chk("grant_onehot", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
        chk("grant_order", 64'(ifu_req_ready), 64'(exp_order[g]));
        g++;
      end
      tick();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk("grant_count", 64'(g), 64'd10);
    mem_ack = mem_req;
    tick();
    mem_ack = 1'b0;
    tick();

    // No ack: timeout after 8 grant cycles, single error and response pulse
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h8000_3000;
    #1;
    chk("to_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_cyc = 0; err_cyc = 0; resp_cyc = 0; both_cyc = 0; other_cyc = 0; resp_d = '1;
    for (int c = 0; c < 20; c++) begin
      if (mem_req) req_cyc++;
      if (bus_err) err_cyc++;
      if (lsu_resp_valid) begin resp_cyc++; resp_d = lsu_resp_data; end
      if (bus_err && lsu_resp_valid) both_cyc++;
      if (ifu_resp_valid) other_cyc++;
      tick();
    end
    chk("to_mem_req_cycles", 64'(req_cyc), 64'd8);
    chk("to_bus_err_pulses", 64'(err_cyc), 64'd1);
    chk("to_resp_pulses", 64'(resp_cyc), 64'd1);
    chk("to_same_cycle", 64'(both_cyc), 64'd1);
    chk("to_resp_data", resp_d, 64'd0);
    chk("to_nonowner", 64'(other_cyc), 64'd0);
    run_vec(vecs[0]);

    // Reset in the 2nd wait cycle of an LSU store abandons it silently
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_4000;
    lsu_req_wdata = 64'h77; lsu_req_wlen = 4'b0001;
    #1;
    chk("rs_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    #1;
    chk("rs_ready_in_rst", 64'(ifu_req_ready), 64'd0);
    ifu_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rs_mem_req_drop", 64'(mem_req), 64'd0);
    req_cyc = 0; err_cyc = 0; resp_cyc = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_req) req_cyc++;
      if (bus_err) err_cyc++;
      if (ifu_resp_valid || lsu_resp_valid) resp_cyc++;
      tick();
    end
    chk("rs_mem_req_cycles", 64'(req_cyc), 64'd0);
    chk("rs_bus_err", 64'(err_cyc), 64'd0);
    chk("rs_resp", 64'(resp_cyc), 64'd0);
    run_vec(vecs[3]);

    // Stray ack while idle produces nothing
    mem_ack = 1'b1;
    mem_rdata = 64'h77;
    tick();
    mem_ack = 1'b0;
    resp_cyc = 0; req_cyc = 0;
    for (int c = 0; c < 3; c++) begin
      if (ifu_resp_valid || lsu_resp_valid) resp_cyc++;
      if (mem_req) req_cyc++;
      tick();
    end
    chk("stray_resp", 64'(resp_cyc), 64'd0);
    chk("stray_mem_req", 64'(req_cyc), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
